// File: rtl/reg_bank.sv
// Multi-word register bank: one byte-masked write port, two registered read
// ports that see the post-write (write-first) state, and a synchronous clear.
module reg_bank #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [WIDTH/8-1:0]   wbe,
   input  logic                 ren_a,
   input  logic [ADDR_W-1:0]    raddr_a,
   output logic [WIDTH-1:0]     rdata_a,
   input  logic                 ren_b,
   input  logic [ADDR_W-1:0]    raddr_b,
   output logic [WIDTH-1:0]     rdata_b
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] mem    [DEPTH];
   logic [WIDTH-1:0] mem_nx [DEPTH];
   logic [WIDTH-1:0] rd_a_nx;
   logic [WIDTH-1:0] rd_b_nx;

   function automatic logic [WIDTH-1:0] byte_merge(
      input logic [WIDTH-1:0] old_w,
      input logic [WIDTH-1:0] new_w,
      input logic [NB-1:0]    be
   );
      logic [WIDTH-1:0] res;
      res = old_w;
      for (int b = 0; b < NB; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

   // Out-of-range addresses never match an entry, so they read as 0.
   function automatic logic [WIDTH-1:0] read_sel(
      input logic [ADDR_W-1:0] addr,
      input logic [WIDTH-1:0]  words [DEPTH]
   );
      logic [WIDTH-1:0] res;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_W'(i)) res = words[i];
      end
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_nx[i] = mem[i];
         if (clr) begin
            mem_nx[i] = '0;
         end else if (we && (waddr == ADDR_W'(i))) begin
            mem_nx[i] = byte_merge(mem[i], wdata, wbe);
         end
      end
      rd_a_nx = read_sel(raddr_a, mem_nx);
      rd_b_nx = read_sel(raddr_b, mem_nx);
   end

   // Register update and read-port capture share one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nx[i];
         if (ren_a) rdata_a <= rd_a_nx;
         if (ren_b) rdata_b <= rd_b_nx;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank (DEPTH=6 so that addresses 6 and 7 are out of range):
// a behavioural word-array model checked every cycle, plus literal checks.
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clr = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wbe = '0;
   logic        ren_a = 1'b0;
   logic [2:0]  raddr_a = '0;
   logic [31:0] rdata_a;
   logic        ren_b = 1'b0;
   logic [2:0]  raddr_b = '0;
   logic [31:0] rdata_b;

   int tests = 0;
   int fails = 0;

   logic [31:0] mdl [6];
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;

   reg_bank #(.WIDTH(32), .DEPTH(6), .ADDR_W(3)) dut (
      .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr),
      .wdata(wdata), .wbe(wbe), .ren_a(ren_a), .raddr_a(raddr_a),
      .rdata_a(rdata_a), .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Model: the bank is an array of words; reads see the array after this
   // edge's clear or write has been applied.
   initial begin
      foreach (mdl[i]) mdl[i] = '0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            foreach (mdl[i]) mdl[i] = '0;
            exp_a = '0;
            exp_b = '0;
         end else begin
            if (clr) begin
               foreach (mdl[i]) mdl[i] = '0;
            end else if (we && int'(waddr) < 6) begin
               for (int b = 0; b < 4; b++)
                  if (wbe[b]) mdl[int'(waddr)][8*b +: 8] = wdata[8*b +: 8];
            end
            if (ren_a) exp_a = (int'(raddr_a) < 6) ? mdl[int'(raddr_a)] : 32'h0;
            if (ren_b) exp_b = (int'(raddr_b) < 6) ? mdl[int'(raddr_b)] : 32'h0;
            #1;
            chk("model_rdata_a", rdata_a, exp_a);
            chk("model_rdata_b", rdata_b, exp_b);
         end
      end
   end

   task automatic drive(input logic c, input logic w, input logic [2:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic ea, input logic [2:0] ra,
                        input logic eb, input logic [2:0] rb);
      clr = c; we = w; waddr = wa; wdata = wd; wbe = be;
      ren_a = ea; raddr_a = ra; ren_b = eb; raddr_b = rb;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b0, 3'd0);
   endtask

   initial begin
      // power-on reset asserted at t=1, between edges
      #1 reset = 1'b0;
      #1;
      chk("por_rdata_a", rdata_a, 32'h0);
      chk("por_rdata_b", rdata_b, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // fill everything with ones, then reset mid-cycle
      for (int k = 0; k < 8; k++)
         drive(1'b0, 1'b1, 3'(k), 32'hFFFFFFFF, 4'hF, 1'b1, 3'(k), 1'b1, 3'(k));
      drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'd1, 1'b1, 3'd2);
      chk("ones_rdata_a", rdata_a, 32'hFFFFFFFF);
      #2 reset = 1'b0;
      #1;
      chk("midreset_rdata_a", rdata_a, 32'h0);
      chk("midreset_rdata_b", rdata_b, 32'h0);
      clr = 1'b0; we = 1'b1; waddr = 3'd1; wdata = 32'h12121212; wbe = 4'hF;
      ren_a = 1'b1; raddr_a = 3'd1; ren_b = 1'b1; raddr_b = 3'd1;
      @(posedge clk);
      #1;
      chk("inreset_rdata_a", rdata_a, 32'h0);
      chk("inreset_rdata_b", rdata_b, 32'h0);
      @(negedge clk);
      idle();
      reset = 1'b1;
      for (int k = 0; k < 8; k++)
         drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'(k), 1'b1, 3'(7 - k));
      chk("postreset_read7_a", rdata_a, 32'h0);

      // byte mask
      drive(1'b0, 1'b1, 3'd3, 32'hAFAFAFAF, 4'hF, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b1, 3'd3, 32'h12345678, 4'b0101, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'd3, 1'b0, 3'd0);
      chk("bytemask_a", rdata_a, 32'hAF34AF78);
      drive(1'b0, 1'b1, 3'd3, 32'h99999999, 4'h0, 1'b0, 3'd0, 1'b1, 3'd3);
      chk("wbe_zero_noop_b", rdata_b, 32'hAF34AF78);

      // forwarding
      drive(1'b0, 1'b1, 3'd4, 32'h44444444, 4'hF, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 1'b1, 3'd5, 1'b1, 3'd4);
      chk("fwd_full_a", rdata_a, 32'hDEADBEEF);
      chk("fwd_other_b", rdata_b, 32'h44444444);
      drive(1'b0, 1'b1, 3'd5, 32'h01020304, 4'b1010, 1'b1, 3'd5, 1'b1, 3'd5);
      chk("fwd_merge_a", rdata_a, 32'h01AD03EF);
      chk("fwd_merge_b", rdata_b, 32'h01AD03EF);

      // clear beats write
      for (int k = 0; k < 8; k++)
         drive(1'b0, 1'b1, 3'(k), 32'(k), 4'hF, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'd2, 1'b1, 3'd5);
      chk("fill_a2", rdata_a, 32'h2);
      chk("fill_b5", rdata_b, 32'h5);
      drive(1'b1, 1'b1, 3'd2, 32'h55555555, 4'hF, 1'b1, 3'd2, 1'b0, 3'd0);
      chk("clr_vs_write_a", rdata_a, 32'h0);
      chk("clr_hold_b", rdata_b, 32'h5);
      for (int k = 0; k < 6; k++)
         drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'(k), 1'b1, 3'(k));
      chk("after_clr_b5", rdata_b, 32'h0);

      // hold while disabled
      drive(1'b0, 1'b1, 3'd1, 32'hCAFEF00D, 4'hF, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'd1, 1'b0, 3'd0);
      chk("hold_initial_a", rdata_a, 32'hCAFEF00D);
      drive(1'b0, 1'b1, 3'd1, 32'h0, 4'hF, 1'b0, 3'd1, 1'b0, 3'd0);
      chk("hold_write_a", rdata_a, 32'hCAFEF00D);
      drive(1'b1, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 3'd1, 1'b0, 3'd0);
      chk("hold_clr_a", rdata_a, 32'hCAFEF00D);
      idle();
      chk("hold_idle_a", rdata_a, 32'hCAFEF00D);

      // out-of-range addresses
      for (int k = 0; k < 6; k++)
         drive(1'b0, 1'b1, 3'(k), 32'hA0A0A0A0 + 32'(k), 4'hF, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b1, 3'd6, 32'hFFFFFFFF, 4'hF, 1'b0, 3'd0, 1'b0, 3'd0);
      drive(1'b0, 1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 1'b1, 3'd6, 1'b1, 3'd7);
      chk("oor_read6_a", rdata_a, 32'h0);
      chk("oor_read7_b", rdata_b, 32'h0);
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1, 3'(k), 1'b0, 3'd0);
         chk("oor_intact_a", rdata_a, 32'hA0A0A0A0 + 32'(k));
      end

      // randomized traffic checked by the model every cycle
      for (int n = 0; n < 2000; n++)
         drive($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits. It has one byte-masked write port, two independent registered read ports with write-first forwarding, and a single-cycle synchronous clear. It is the next generation of the team's fixed-width register: it stores multiple words and gives the datapath 1-cycle-latency operand reads.

## Interface
Parameters:
- WIDTH, 32, word width in bits; must be a multiple of 8
- DEPTH, 8, number of registers; any value 2..256 (power of 2 not required)
- ADDR_W, 3, address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
- clk  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-low reset; one clock domain
- clr  in  1  synchronous clear of all registers
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- wbe  in  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- ren_a  in  1  read enable, port A
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  WIDTH  registered read data, port A
- ren_b  in  1  read enable, port B
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  WIDTH  registered read data, port B

## Operation
- **Reset (reset=0):** all DEPTH registers, rdata_a and rdata_b go to 0 immediately, with no clock required. They stay 0 while reset is low. clr, we and ren are ignored while reset is low. Reset is honoured mid-write.
- **Priority per rising edge:** clr, then write. Reads always see the post-update state (write-first).
- **Clear (clr=1):** every register becomes 0 at the edge. A write in the same cycle is discarded.
- **Write (we=1, clr=0, waddr < DEPTH):**
  - Each lane i with wbe[i]=1 takes wdata[8i+7:8i].
  - Lanes with wbe[i]=0 keep their old value.
  - wbe all 0 is a legal no-op.
- **Out-of-range write (waddr >= DEPTH):** ignored; no register changes.
- **Read (ren_x=1):** rdata_x loads the next-state value of register raddr_x at the edge.
  - If clr=1, the loaded value is 0.
  - If a write hits raddr_x in the same cycle, the loaded value is the merged word: new enabled bytes plus old unenabled bytes.
  - Otherwise it is the stored value.
- **Out-of-range read (raddr_x >= DEPTH, ren_x=1):** rdata_x loads 0.
- **Read disabled (ren_x=0):** rdata_x holds its previous value, including across a clr or a write to the same address.
- **Port independence:** ports A and B are fully independent. The same address on both ports is legal and yields identical data.
- **Widths:** no arithmetic; all paths are bit-exact WIDTH.

## Timing
- **Read latency:** 1 cycle. Address and ren are sampled at edge N; data is valid after edge N and until the next enabled read edge.
- **Write latency:** visible to a read issued in the same cycle via forwarding. Visible to all later reads.
- **Clear:** takes one edge. Reads in the same cycle return 0.
- **Handshakes/back-pressure:** none. One write and two reads are accepted every cycle.
- **Reset release:** the first edge with reset=1 is a normal functional edge.
- **Reset assertion:** asynchronous. Outputs are 0 within the same delta, independent of clk.

## Test plan
- **Reset:** assert reset=0 at t=1 mid-cycle after prior writes of 32'hFFFFFFFF to all registers -> rdata_a = rdata_b = 0 immediately. After release, reads of every address return 32'h00000000.
- **Byte mask:**
  - Write 32'hAFAFAFAF, wbe=4'hF to addr 3.
  - Then write 32'h12345678, wbe=4'b0101 to addr 3.
  - Read A addr 3 one cycle later -> 32'hAF34AF78.
- **Forwarding:**
  - Same cycle: we=1, waddr=5, wdata=32'hDEADBEEF, wbe=4'hF; ren_a=1, raddr_a=5; ren_b=1, raddr_b=4.
  - Next cycle -> rdata_a = 32'hDEADBEEF, rdata_b = old addr-4 value.
- **Clear vs write:**
  - Fill addrs 0..7 with 32'h0000000k (k = address).
  - Assert clr=1 together with we=1, waddr=2, wdata=32'h55555555; ren_a=1, raddr_a=2.
  - Expect rdata_a = 0 next cycle, and all addresses read 0 afterwards.
- **Hold:**
  - Read A addr 1 (value 32'hCAFEF00D).
  - Then ren_a=0 while writing 32'h0 to addr 1 and pulsing clr.
  - Expect rdata_a stays 32'hCAFEF00D for all those cycles.
- **Out-of-range (DEPTH=6, ADDR_W=3):**
  - Write 32'hFFFFFFFF to addr 6 and 7.
  - Expect reads of 6 and 7 return 0, and addrs 0..5 are unchanged.
